// File: rtl/buzzer_seq_player.sv
// buzzer_seq_player: note sequencer front-end for a piezo buzzer.
// Accepts one note command per valid/ready handshake. Each note is played as
// a square wave for an exact number of duration ticks, followed by a fixed
// silent gap. Half-periods come from a 16-entry table (cycles at 50 MHz),
// shifted right by the octave field at accept time.
//
// Ports:
//   FPGA_CLK    system clock
//   FPGA_RST_N  asynchronous active-low reset
//   cmd_valid   command present
//   cmd_ready   block can accept a command (IDLE and no abort)
//   cmd_note    note index into the half-period table
//   cmd_octave  half-period right-shift count
//   cmd_dur     note length in ticks (0 = complete immediately, no tone)
//   cmd_rest    1 = silent note of the same duration
//   abort       stop the current note at the next edge, no done pulse
//   mute        level gate on beep; timing and tone phase keep running
//   busy        FSM not idle
//   done        one-cycle pulse when a note and its gap complete
//   beep        registered buzzer drive
module buzzer_seq_player #(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned TICK_HZ   = 1000,
    parameter int unsigned NOTE_W    = 4,
    parameter int unsigned DUR_W     = 8,
    parameter int unsigned GAP_TICKS = 10,
    parameter int unsigned DIV_W     = 22
) (
    input  logic              FPGA_CLK,
    input  logic              FPGA_RST_N,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [NOTE_W-1:0] cmd_note,
    input  logic [1:0]        cmd_octave,
    input  logic [DUR_W-1:0]  cmd_dur,
    input  logic              cmd_rest,
    input  logic              abort,
    input  logic              mute,
    output logic              busy,
    output logic              done,
    output logic              beep
);

    localparam int unsigned TICK_DIV_RAW = CLK_HZ / TICK_HZ;
    localparam int unsigned TICK_DIV     = (TICK_DIV_RAW < 1) ? 1 : TICK_DIV_RAW;
    localparam int unsigned PRE_W        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned GAP_W        = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TONE = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    // Half-period lookup; indexes beyond the table yield 0 (silent note).
    function automatic logic [DIV_W-1:0] hp_lookup(input logic [NOTE_W-1:0] note);
        logic [15:0] hp;
        int unsigned idx;
        idx = 32'(note);
        case (idx)
            0:       hp = 16'd28409;
            1:       hp = 16'd25329;
            2:       hp = 16'd23900;
            3:       hp = 16'd21294;
            4:       hp = 16'd18968;
            5:       hp = 16'd17908;
            6:       hp = 16'd15943;
            7:       hp = 16'd14204;
            8:       hp = 16'd12658;
            9:       hp = 16'd11944;
            10:      hp = 16'd10642;
            11:      hp = 16'd9480;
            12:      hp = 16'd8950;
            13:      hp = 16'd7971;
            14:      hp = 16'd7102;
            15:      hp = 16'd6327;
            default: hp = 16'd0;
        endcase
        return DIV_W'(hp);
    endfunction

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  hp_q, hp_d;
    logic [DIV_W-1:0]  tone_q, tone_d;
    logic              phase_q, phase_d;
    logic              rest_q, rest_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic              zero_q, zero_d;
    logic              beep_q, beep_d;
    logic              done_q, done_d;

    logic              tick_wrap;
    logic              tone_wrap;
    logic              phase_next;
    logic [PRE_W-1:0]  pre_next;
    logic              accept;

    assign cmd_ready = (state_q == S_IDLE) & ~abort;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign beep      = beep_q;

    // State register and datapath registers.
    always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
        if (!FPGA_RST_N) begin
            state_q <= S_IDLE;
            hp_q    <= '0;
            tone_q  <= '0;
            phase_q <= 1'b0;
            rest_q  <= 1'b0;
            dur_q   <= '0;
            gap_q   <= '0;
            pre_q   <= '0;
            zero_q  <= 1'b0;
            beep_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            tone_q  <= tone_d;
            phase_q <= phase_d;
            rest_q  <= rest_d;
            dur_q   <= dur_d;
            gap_q   <= gap_d;
            pre_q   <= pre_d;
            zero_q  <= zero_d;
            beep_q  <= beep_d;
            done_q  <= done_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        tone_d  = tone_q;
        phase_d = phase_q;
        rest_d  = rest_q;
        dur_d   = dur_q;
        gap_d   = gap_q;
        pre_d   = pre_q;
        zero_d  = 1'b0;
        beep_d  = 1'b0;
        done_d  = 1'b0;

        tick_wrap  = (pre_q == PRE_W'(TICK_DIV - 1));
        pre_next   = tick_wrap ? '0 : pre_q + PRE_W'(1);
        // hp==0 never wraps, so the phase stays low and beep stays silent
        tone_wrap  = (hp_q != '0) && (tone_q == hp_q - DIV_W'(1));
        phase_next = phase_q ^ tone_wrap;
        accept     = cmd_valid & ~abort;

        unique case (state_q)
            S_IDLE: begin
                // zero-length note completes one cycle after its accept edge
                done_d = zero_q;
                if (accept) begin
                    hp_d    = hp_lookup(cmd_note) >> cmd_octave;
                    dur_d   = cmd_dur;
                    rest_d  = cmd_rest;
                    pre_d   = '0;
                    tone_d  = '0;
                    phase_d = 1'b0;
                    if (cmd_dur == '0) begin
                        zero_d = 1'b1;
                    end else begin
                        state_d = S_TONE;
                    end
                end
            end

            S_TONE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    pre_d   = pre_next;
                    phase_d = phase_next;
                    tone_d  = (tone_wrap || (hp_q == '0)) ? '0 : tone_q + DIV_W'(1);
                    if (tick_wrap) begin
                        dur_d = dur_q - DUR_W'(1);
                        if (dur_q == DUR_W'(1)) begin
                            if (GAP_TICKS > 0) begin
                                state_d = S_GAP;
                                gap_d   = GAP_W'(GAP_TICKS);
                                pre_d   = '0;
                            end else begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                    // beep is forced low on the edge that leaves TONE
                    if (state_d == S_TONE) begin
                        beep_d = phase_next & ~rest_q & ~mute & (hp_q != '0);
                    end
                end
            end

            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    pre_d = pre_next;
                    if (tick_wrap) begin
                        gap_d = gap_q - GAP_W'(1);
                        if (gap_q == GAP_W'(1)) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_buzzer_seq_player.sv
// Directed self-checking bench for buzzer_seq_player.
// Runs with a scaled time base (1000 cycles per tick, 2-tick gap) so every
// note completes in a few thousand cycles; half-periods use the real table.
// A negedge monitor records beep rise edges, done pulses and busy falls
// relative to a per-note generation counter; the main sequence checks them.
module tb_buzzer_seq_player;

    localparam int unsigned NOTE_W = 5;
    localparam int unsigned DUR_W  = 8;
    localparam logic [31:0] NONE   = 32'hFFFF_FFFF;

    logic              FPGA_CLK   = 1'b0;
    logic              FPGA_RST_N = 1'b1;
    logic              cmd_valid  = 1'b0;
    logic              cmd_ready;
    logic [NOTE_W-1:0] cmd_note   = '0;
    logic [1:0]        cmd_octave = '0;
    logic [DUR_W-1:0]  cmd_dur    = '0;
    logic              cmd_rest   = 1'b0;
    logic              abort      = 1'b0;
    logic              mute       = 1'b0;
    logic              busy;
    logic              done;
    logic              beep;

    buzzer_seq_player #(
        .CLK_HZ   (100000),
        .TICK_HZ  (100),
        .NOTE_W   (NOTE_W),
        .DUR_W    (DUR_W),
        .GAP_TICKS(2),
        .DIV_W    (22)
    ) dut (
        .FPGA_CLK  (FPGA_CLK),
        .FPGA_RST_N(FPGA_RST_N),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_note  (cmd_note),
        .cmd_octave(cmd_octave),
        .cmd_dur   (cmd_dur),
        .cmd_rest  (cmd_rest),
        .abort     (abort),
        .mute      (mute),
        .busy      (busy),
        .done      (done),
        .beep      (beep)
    );

    always #5 FPGA_CLK = ~FPGA_CLK;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0] edge_cnt = 32'd0;
    always @(posedge FPGA_CLK) edge_cnt <= edge_cnt + 32'd1;

    // Per-note observations, cleared whenever the sequence bumps gen.
    logic [31:0] gen        = 32'd0;
    logic [31:0] mon_gen    = 32'd0;
    logic [31:0] exp_period = 32'd1;
    logic [31:0] first_rise = NONE;
    logic [31:0] last_hi    = NONE;
    logic [31:0] done_edge  = NONE;
    logic [31:0] busy_fall  = NONE;
    logic [31:0] rises      = 32'd0;
    logic [31:0] bad_period = 32'd0;
    logic [31:0] dones      = 32'd0;
    logic [31:0] busy_hi    = 32'd0;
    logic [31:0] mute_viol  = 32'd0;
    logic        pbeep      = 1'b0;
    logic        pbusy      = 1'b0;

    always @(negedge FPGA_CLK) begin
        if (mon_gen != gen) begin
            first_rise = NONE;
            last_hi    = NONE;
            done_edge  = NONE;
            busy_fall  = NONE;
            rises      = 32'd0;
            bad_period = 32'd0;
            dones      = 32'd0;
            busy_hi    = 32'd0;
            mute_viol  = 32'd0;
            mon_gen    = gen;
        end
        if (beep === 1'b1 && pbeep !== 1'b1) begin
            rises = rises + 32'd1;
            if (first_rise == NONE) first_rise = edge_cnt;
            else if (((edge_cnt - first_rise) % exp_period) != 32'd0) bad_period = bad_period + 32'd1;
        end
        if (beep === 1'b1) last_hi = edge_cnt;
        if (beep === 1'b1 && mute === 1'b1) mute_viol = mute_viol + 32'd1;
        if (done === 1'b1) begin
            dones     = dones + 32'd1;
            done_edge = edge_cnt;
        end
        if (busy === 1'b1) busy_hi = busy_hi + 32'd1;
        if (pbusy === 1'b1 && busy === 1'b0) busy_fall = edge_cnt;
        pbeep = beep;
        pbusy = busy;
    end

    logic [31:0] acc = 32'd0;
    logic [31:0] d1  = 32'd0;

    task automatic step();
        @(negedge FPGA_CLK);
        #1;
    endtask

    task automatic run_to(input logic [31:0] e);
        while (edge_cnt < e) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic send(input logic [NOTE_W-1:0] n, input logic [1:0] o,
                        input logic [DUR_W-1:0] d, input logic r);
        cmd_note   = n;
        cmd_octave = o;
        cmd_dur    = d;
        cmd_rest   = r;
        cmd_valid  = 1'b1;
        @(posedge FPGA_CLK);
        #1;
        cmd_valid = 1'b0;
        acc       = edge_cnt;
        gen       = gen + 32'd1;
    endtask

    initial begin
        // reset values while reset is held
        #1 FPGA_RST_N = 1'b0;
        step();
        step();
        check_bit("rst_beep", beep, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_ready", cmd_ready, 1'b1);
        FPGA_RST_N = 1'b1;
        step();
        step();

        // note 15 oct 3: hp 790, 3 ticks + 2-tick gap; next command queued meanwhile
        exp_period = 32'd1580;
        send(5'd15, 2'd3, 8'd3, 1'b0);
        check_bit("n1_busy", busy, 1'b1);
        check_bit("n1_ready", cmd_ready, 1'b0);
        cmd_note   = 5'd0;
        cmd_octave = 2'd3;
        cmd_dur    = 8'd11;
        cmd_valid  = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            step();
            if (done === 1'b1) break;
        end
        check("n1_first_rise", first_rise - acc, 32'd790);
        check("n1_rises", rises, 32'd2);
        check("n1_period", bad_period, 32'd0);
        check("n1_last_hi", last_hi - acc, 32'd2999);
        check("n1_done_edge", done_edge - acc, 32'd5000);
        check("n1_busy_fall", busy_fall - acc, 32'd5000);
        check_bit("n1_ready_at_done", cmd_ready, 1'b1);
        d1 = done_edge;

        // back-to-back accept in the done cycle: note 0 oct 3, hp 3551
        @(posedge FPGA_CLK);
        #1;
        cmd_valid  = 1'b0;
        acc        = edge_cnt;
        gen        = gen + 32'd1;
        exp_period = 32'd7102;
        check("b2b_gap", acc - d1, 32'd1);
        check_bit("n2_busy", busy, 1'b1);
        run_to(acc + 32'd13001);
        check("n2_first_rise", first_rise - acc, 32'd3551);
        check("n2_rises", rises, 32'd2);
        check("n2_period", bad_period, 32'd0);
        check("n2_last_hi", last_hi - acc, 32'd10999);
        check("n2_done_edge", done_edge - acc, 32'd13000);
        check("n2_dones", dones, 32'd1);
        check_bit("n2_done_pulse_end", done, 1'b0);

        // note 15 oct 2: hp 1581
        exp_period = 32'd3162;
        send(5'd15, 2'd2, 8'd5, 1'b0);
        run_to(acc + 32'd7001);
        check("n3_first_rise", first_rise - acc, 32'd1581);
        check("n3_rises", rises, 32'd2);
        check("n3_period", bad_period, 32'd0);
        check("n3_done_edge", done_edge - acc, 32'd7000);

        // rest note: silent for 1 tick + gap
        send(5'd9, 2'd0, 8'd1, 1'b1);
        run_to(acc + 32'd3001);
        check("rest_rises", rises, 32'd0);
        check("rest_done_edge", done_edge - acc, 32'd3000);
        check("rest_busy_fall", busy_fall - acc, 32'd3000);

        // zero duration: done one cycle after accept, never busy
        send(5'd9, 2'd0, 8'd0, 1'b0);
        check_bit("z_busy", busy, 1'b0);
        check_bit("z_done_k", done, 1'b0);
        run_to(acc + 32'd1);
        check_bit("z_done_k1", done, 1'b1);
        run_to(acc + 32'd2);
        check_bit("z_done_k2", done, 1'b0);
        check("z_dones", dones, 32'd1);
        check("z_busy_hi", busy_hi, 32'd0);

        // out-of-table index: hp 0, silent but timed
        send(5'd16, 2'd0, 8'd2, 1'b0);
        run_to(acc + 32'd1000);
        check_bit("hp0_busy", busy, 1'b1);
        run_to(acc + 32'd4001);
        check("hp0_rises", rises, 32'd0);
        check("hp0_done_edge", done_edge - acc, 32'd4000);

        // abort mid-note, then abort with valid in IDLE
        exp_period = 32'd1580;
        send(5'd15, 2'd3, 8'd3, 1'b0);
        run_to(acc + 32'd1200);
        check_bit("ab_beep_before", beep, 1'b1);
        abort = 1'b1;
        run_to(acc + 32'd1201);
        check_bit("ab_beep", beep, 1'b0);
        check_bit("ab_busy", busy, 1'b0);
        check_bit("ab_ready", cmd_ready, 1'b0);
        check_bit("ab_done", done, 1'b0);
        cmd_valid = 1'b1;
        cmd_dur   = 8'd2;
        run_to(acc + 32'd1203);
        check_bit("ab_valid_blocked", busy, 1'b0);
        cmd_valid = 1'b0;
        abort     = 1'b0;
        step();
        check_bit("ab_ready_release", cmd_ready, 1'b1);
        run_to(acc + 32'd5000);
        check("ab_dones", dones, 32'd0);
        check("ab_rises", rises, 32'd1);

        // mute while phase low, released while phase low
        exp_period = 32'd1580;
        send(5'd15, 2'd3, 8'd6, 1'b0);
        run_to(acc + 32'd1700);
        mute = 1'b1;
        run_to(acc + 32'd3000);
        check_bit("mute_beep", beep, 1'b0);
        run_to(acc + 32'd3500);
        mute = 1'b0;
        run_to(acc + 32'd4000);
        check_bit("mute_resume", beep, 1'b1);
        run_to(acc + 32'd8001);
        check("mute_first_rise", first_rise - acc, 32'd790);
        check("mute_rises", rises, 32'd3);
        check("mute_period", bad_period, 32'd0);
        check("mute_viol", mute_viol, 32'd0);
        check("mute_last_hi", last_hi - acc, 32'd5999);
        check("mute_done_edge", done_edge - acc, 32'd8000);

        // async reset between clock edges mid-tone
        send(5'd15, 2'd3, 8'd3, 1'b0);
        run_to(acc + 32'd900);
        check_bit("ar_beep_before", beep, 1'b1);
        #1 FPGA_RST_N = 1'b0;
        #1;
        check_bit("ar_beep", beep, 1'b0);
        check_bit("ar_busy", busy, 1'b0);
        check_bit("ar_done", done, 1'b0);
        check_bit("ar_ready", cmd_ready, 1'b1);
        run_to(acc + 32'd905);
        FPGA_RST_N = 1'b1;
        step();
        check_bit("ar_ready_after", cmd_ready, 1'b1);
        check("ar_dones", dones, 32'd0);
        send(5'd15, 2'd3, 8'd2, 1'b0);
        run_to(acc + 32'd4001);
        check("ar_n_first_rise", first_rise - acc, 32'd790);
        check("ar_n_rises", rises, 32'd1);
        check("ar_n_done_edge", done_edge - acc, 32'd4000);
        check("ar_n_dones", dones, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/buzzer_seq_player.md
Name: buzzer_seq_player

Overview:
- Parametrised successor to the single-tone buzzer controller.
- Accepts note commands over a valid/ready handshake: note index, octave shift, duration and rest flag.
- Plays each note as a square wave for an exact duration, then holds an inter-note silent gap.
- Sits between the melody/sequence source (ROM walker or UI FSM) and the buzzer pin.

Parameters:
- CLK_HZ, 50000000, FPGA_CLK frequency in Hz.
- TICK_HZ, 1000, duration time base; one tick = CLK_HZ/TICK_HZ cycles (TICK_DIV, integer, >=1).
- NOTE_W, 4, width of cmd_note.
- DUR_W, 8, width of cmd_dur (ticks).
- GAP_TICKS, 10, silent ticks after each note; 0 = no gap.
- DIV_W, 22, width of half-period and tone counters.

Ports:
- FPGA_CLK  in  1  system clock.
- FPGA_RST_N  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_note  in  NOTE_W  note index.
- cmd_octave  in  2  half-period right-shift count (0..3 octaves up).
- cmd_dur  in  DUR_W  note length in ticks.
- cmd_rest  in  1  1 = silent note of the same duration.
- abort  in  1  stop the current note immediately.
- mute  in  1  level input; forces beep low without affecting timing.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a note plus its gap completes.
- beep  out  1  buzzer drive.

Behaviour:
- Reset (async, FPGA_RST_N low):
  - state=IDLE; beep=0, done=0, busy=0.
  - All counters 0; tone phase 0.
  - cmd_ready = (state==IDLE) & ~abort, so it is 1 during reset when abort=0.
- Half-period table HP[note], decimal cycles at 50 MHz:
  - 0:28409, 1:25329, 2:23900, 3:21294, 4:18968, 5:17908, 6:15943, 7:14204
  - 8:12658, 9:11944, 10:10642, 11:9480, 12:8950, 13:7971, 14:7102, 15:6327
  - Indexes >15 (NOTE_W>4) give HP=0.
  - Effective hp = HP[note] >> cmd_octave, computed at accept time and latched.
- FSM states IDLE, TONE, GAP.
- IDLE:
  - Accept on cmd_valid & cmd_ready (edge k).
  - At edge k, latch hp, dur and rest; clear tick prescaler, tick counter, tone counter and tone phase.
  - cmd_dur==0: stay IDLE, done=1 at edge k+1, no tone.
  - Otherwise go to TONE at edge k.
- TONE:
  - Tone counter runs 0..hp-1; at hp-1 the phase toggles and the counter wraps to 0.
  - beep is registered: beep <= phase_next & ~rest & ~mute & (hp!=0).
  - First rising edge of beep occurs exactly hp cycles after edge k; beep then toggles every hp cycles (period 2*hp).
  - hp==0 → beep held 0, duration still honoured.
  - Tick prescaler counts 0..TICK_DIV-1; each wrap decrements dur.
  - TONE lasts exactly dur*TICK_DIV cycles.
  - At the end: go to GAP if GAP_TICKS>0, else IDLE. beep=0 on that same edge regardless of phase.
- GAP:
  - beep=0 for exactly GAP_TICKS*TICK_DIV cycles, then IDLE.
- done:
  - Single-cycle pulse, asserted on the edge the FSM enters IDLE from normal completion.
  - cmd_ready is also 1 in that cycle, so back-to-back commands add zero dead cycles.
- abort:
  - In TONE or GAP: next edge → IDLE, beep=0, done NOT pulsed.
  - In IDLE: blocks acceptance in that cycle.
  - abort and cmd_valid in the same cycle: abort wins.
- mute: toggling mid-note only gates beep; phase and counters continue, so unmuting resumes in phase.
- cmd_* inputs are ignored when not accepted; changes during TONE/GAP have no effect.
- Reset asserted mid-note: beep falls asynchronously; no done pulse.

Test Plan:
- Defaults; note=9, octave=0, dur=2, rest=0 → beep period 23888 cycles, first rise 11944 cycles after accept; TONE lasts 100000 cycles; GAP 500000 cycles; done pulses once; cmd_ready returns the same cycle.
- note=0, octave=3 → half-period 3551 (28409>>3), period 7102; note=15, octave=2 → half-period 1581.
- rest=1, dur=1 → beep stays 0 for 50000+500000 cycles, then done; cmd_dur=0 → done 1 cycle after accept, busy never set.
- Assert abort 20000 cycles into a dur=3 note → beep 0 and busy 0 next cycle, no done; with abort and cmd_valid high in IDLE → not accepted.
- Toggle mute high for 30000 cycles mid-note → beep low throughout; after release, edges align to the original 2*hp grid; total duration unchanged.
- Pull FPGA_RST_N low mid-TONE between clock edges → beep, busy and done go 0 immediately; after release cmd_ready=1 and a new note plays correctly.
